// File: rtl/traffic_pkg.sv
// Shared encodings for the intersection phase controller: phase codes, lamp patterns, timer width.
package traffic_pkg;

   localparam int unsigned SEC_W = 8;
   typedef logic [SEC_W-1:0] sec_t;

   typedef enum logic [2:0] {
      NS_GREEN  = 3'd0,
      NS_YELLOW = 3'd1,
      ALL_RED_1 = 3'd2,
      EW_GREEN  = 3'd3,
      EW_YELLOW = 3'd4,
      ALL_RED_2 = 3'd5,
      FLASH     = 3'd6
   } phase_e;

   // Lamp order is {red, yellow, green}
   localparam logic [2:0] RED = 3'b100;
   localparam logic [2:0] YEL = 3'b010;
   localparam logic [2:0] GRN = 3'b001;
   localparam logic [2:0] OFF = 3'b000;

endpackage

// File: rtl/tick_gen.sv
// One-cycle enable pulse every TICK_DIV clocks; clr holds the count at zero and suppresses the pulse.
module tick_gen #(
   parameter int unsigned TICK_DIV = 100_000_000
) (
   input  logic clk_100MHz,
   input  logic rstn,
   input  logic clr,
   output logic tick
);

   localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      tick  = 1'b0;
      cnt_d = cnt_q + CW'(1);
      if (clr) begin
         cnt_d = '0;
      end else if (cnt_q == LAST) begin
         tick  = 1'b1;
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk_100MHz or negedge rstn) begin
      if (!rstn) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-way intersection phase sequencer with pedestrian green truncation.
// Define TRAFFIC_NIGHT_FLASH_EN to add the night input and the flashing-yellow phase.
module traffic_phase_ctrl
   import traffic_pkg::*;
#(
   parameter int unsigned TICK_DIV    = 100_000_000,
   parameter int unsigned GREEN_S     = 20,
   parameter int unsigned YELLOW_S    = 3,
   parameter int unsigned ALLRED_S    = 1,
   parameter int unsigned MIN_GREEN_S = 5
) (
   input  logic       clk_100MHz,
   input  logic       rstn,
   input  logic       enable,
   input  logic       ped_req,
`ifdef TRAFFIC_NIGHT_FLASH_EN
   input  logic       night,
`endif
   output logic [2:0] ns_light,
   output logic [2:0] ew_light,
   output logic [2:0] phase,
   output logic [7:0] sec_left,
   output logic       ped_pending
);

   localparam sec_t GREEN  = sec_t'(GREEN_S);
   localparam sec_t YELLOW = sec_t'(YELLOW_S);
   localparam sec_t ALLRED = sec_t'(ALLRED_S);
   localparam sec_t MING   = sec_t'(MIN_GREEN_S);

   phase_e     phase_q, phase_d;
   sec_t       sec_q, sec_d;
   logic [2:0] ns_q, ns_d, ew_q, ew_d;
   logic       ped_q, ped_d;
   logic       tick;

   tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick_gen (
      .clk_100MHz (clk_100MHz),
      .rstn       (rstn),
      .clr        (~enable),
      .tick       (tick)
   );

   always_comb begin
      phase_d = phase_q;
      sec_d   = sec_q;
      ns_d    = ns_q;
      ew_d    = ew_q;
      ped_d   = ped_q | ped_req;
      if (!enable) begin
         phase_d = ALL_RED_2;
         sec_d   = ALLRED;
         ns_d    = RED;
         ew_d    = RED;
      end else begin
         case (phase_q)
            NS_GREEN, EW_GREEN: begin
               // A pending or same-cycle request wins over the tick decrement
               if (ped_d && (sec_q > MING)) begin
                  sec_d = MING;
               end else if (tick) begin
                  if (sec_q <= sec_t'(1)) begin
                     sec_d = YELLOW;
                     ped_d = 1'b0;
                     if (phase_q == NS_GREEN) begin
                        phase_d = NS_YELLOW;
                        ns_d    = YEL;
                        ew_d    = RED;
                     end else begin
                        phase_d = EW_YELLOW;
                        ns_d    = RED;
                        ew_d    = YEL;
                     end
                  end else begin
                     sec_d = sec_q - sec_t'(1);
                  end
               end
            end
            NS_YELLOW, EW_YELLOW: begin
               if (tick) begin
                  if (sec_q <= sec_t'(1)) begin
                     sec_d = ALLRED;
                     ns_d  = RED;
                     ew_d  = RED;
                     if (phase_q == NS_YELLOW) phase_d = ALL_RED_1;
                     else                      phase_d = ALL_RED_2;
                  end else begin
                     sec_d = sec_q - sec_t'(1);
                  end
               end
            end
            ALL_RED_1, ALL_RED_2: begin
               if (tick) begin
                  if (sec_q <= sec_t'(1)) begin
                     sec_d = GREEN;
                     if (phase_q == ALL_RED_1) begin
                        phase_d = EW_GREEN;
                        ns_d    = RED;
                        ew_d    = GRN;
                     end else begin
                        phase_d = NS_GREEN;
                        ns_d    = GRN;
                        ew_d    = RED;
                     end
`ifdef TRAFFIC_NIGHT_FLASH_EN
                     if (night) begin
                        phase_d = FLASH;
                        sec_d   = '0;
                        ns_d    = YEL;
                        ew_d    = YEL;
                        ped_d   = 1'b0;
                     end
`endif
                  end else begin
                     sec_d = sec_q - sec_t'(1);
                  end
               end
            end
`ifdef TRAFFIC_NIGHT_FLASH_EN
            FLASH: begin
               sec_d = '0;
               ped_d = 1'b0;
               if (tick) begin
                  if (!night) begin
                     phase_d = ALL_RED_2;
                     sec_d   = ALLRED;
                     ns_d    = RED;
                     ew_d    = RED;
                  end else begin
                     ns_d = (ns_q == YEL) ? OFF : YEL;
                     ew_d = (ns_q == YEL) ? OFF : YEL;
                  end
               end
            end
`endif
            default: begin
               phase_d = ALL_RED_2;
               sec_d   = ALLRED;
               ns_d    = RED;
               ew_d    = RED;
            end
         endcase
      end
   end

   always_ff @(posedge clk_100MHz or negedge rstn) begin
      if (!rstn) begin
         phase_q <= ALL_RED_2;
         sec_q   <= ALLRED;
         ns_q    <= RED;
         ew_q    <= RED;
         ped_q   <= 1'b0;
      end else begin
         phase_q <= phase_d;
         sec_q   <= sec_d;
         ns_q    <= ns_d;
         ew_q    <= ew_d;
         ped_q   <= ped_d;
      end
   end

   assign ns_light    = ns_q;
   assign ew_light    = ew_q;
   assign phase       = phase_q;
   assign sec_left    = sec_q;
   assign ped_pending = ped_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Directed bench for traffic_phase_ctrl: expected snapshots queued per clock edge, checked on arrival.
module tb_traffic_phase_ctrl;

   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] Y = 3'b010;
   localparam logic [2:0] G = 3'b001;
   localparam logic [2:0] O = 3'b000;

   logic       clk_100MHz = 1'b0;
   logic       rstn;
   logic       enable;
   logic       ped_req;
`ifdef TRAFFIC_NIGHT_FLASH_EN
   logic       night;
`endif
   logic [2:0] ns_light, ew_light, phase;
   logic [7:0] sec_left;
   logic       ped_pending;

   int npass = 0;
   int nfail = 0;
   int ntotal = 0;
   int ecnt;

   typedef struct {
      int         at;
      string      tag;
      logic [2:0] ph;
      logic [7:0] sec;
      logic [2:0] ns;
      logic [2:0] ew;
      logic       ped;
   } exp_t;

   exp_t sbq[$];

   traffic_phase_ctrl #(
      .TICK_DIV    (4),
      .GREEN_S     (6),
      .YELLOW_S    (2),
      .ALLRED_S    (1),
      .MIN_GREEN_S (2)
   ) dut (
      .clk_100MHz  (clk_100MHz),
      .rstn        (rstn),
      .enable      (enable),
      .ped_req     (ped_req),
`ifdef TRAFFIC_NIGHT_FLASH_EN
      .night       (night),
`endif
      .ns_light    (ns_light),
      .ew_light    (ew_light),
      .phase       (phase),
      .sec_left    (sec_left),
      .ped_pending (ped_pending)
   );

   always #5 clk_100MHz = ~clk_100MHz;

   // Clock edges since the last reset release
   always @(posedge clk_100MHz or negedge rstn) begin
      if (!rstn) ecnt <= 0;
      else       ecnt <= ecnt + 1;
   end

   task automatic chk(input string tag, input int obs, input int exp_v);
      ntotal++;
      assert (obs === exp_v) npass++;
      else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   task automatic push(input int at, input string tag, input logic [2:0] ph, input logic [7:0] sec,
                       input logic [2:0] ns, input logic [2:0] ew, input logic ped);
      exp_t e;
      e.at = at; e.tag = tag; e.ph = ph; e.sec = sec; e.ns = ns; e.ew = ew; e.ped = ped;
      sbq.push_back(e);
   endtask

   task automatic snap(input exp_t e);
      chk({e.tag, ".phase"}, int'(phase), int'(e.ph));
      chk({e.tag, ".sec"}, int'(sec_left), int'(e.sec));
      chk({e.tag, ".ns"}, int'(ns_light), int'(e.ns));
      chk({e.tag, ".ew"}, int'(ew_light), int'(e.ew));
      chk({e.tag, ".ped"}, int'(ped_pending), int'(e.ped));
   endtask

   // Pops every queued expectation, waiting (bounded) for the edge it belongs to
   task automatic drain();
      exp_t e;
      int   guard;
      while (sbq.size() > 0) begin
         e = sbq.pop_front();
         guard = 0;
         while (ecnt < e.at && guard < 2000) begin
            @(negedge clk_100MHz);
            guard++;
         end
         chk({e.tag, ".edge"}, ecnt, e.at);
         snap(e);
      end
   endtask

   initial begin
      exp_t rv;
      rstn    = 1'b0;
      enable  = 1'b1;
      ped_req = 1'b0;
`ifdef TRAFFIC_NIGHT_FLASH_EN
      night   = 1'b0;
`endif
      repeat (2) @(negedge clk_100MHz);
      rv.tag = "reset"; rv.ph = 3'd5; rv.sec = 8'd1; rv.ns = R; rv.ew = R; rv.ped = 1'b0; rv.at = 0;
      snap(rv);
      rstn = 1'b1;

      // Free-running cycle, no pedestrian
      push(3,  "ar2_hold", 3'd5, 8'd1, R, R, 1'b0);
      push(4,  "ns_g",     3'd0, 8'd6, G, R, 1'b0);
      push(27, "ns_g_end", 3'd0, 8'd1, G, R, 1'b0);
      push(28, "ns_y",     3'd1, 8'd2, Y, R, 1'b0);
      push(36, "ar1",      3'd2, 8'd1, R, R, 1'b0);
      push(40, "ew_g",     3'd3, 8'd6, R, G, 1'b0);
      push(64, "ew_y",     3'd4, 8'd2, R, Y, 1'b0);
      push(72, "ar2",      3'd5, 8'd1, R, R, 1'b0);
      push(76, "ns_g2",    3'd0, 8'd6, G, R, 1'b0);
      push(80, "ns_g5",    3'd0, 8'd5, G, R, 1'b0);
      drain();

      // Pulse at sec_left=5 truncates to MIN_GREEN
      ped_req = 1'b1;
      push(81, "ped_trunc", 3'd0, 8'd2, G, R, 1'b1);
      drain();
      ped_req = 1'b0;
      push(84,  "ped_tick",   3'd0, 8'd1, G, R, 1'b1);
      push(88,  "ped_clr_y",  3'd1, 8'd2, Y, R, 1'b0);
      push(100, "ew_g3",      3'd3, 8'd6, R, G, 1'b0);
      push(116, "ew_g_sec2",  3'd3, 8'd2, R, G, 1'b0);
      drain();

      // Request at sec_left<=MIN_GREEN: no truncation
      ped_req = 1'b1;
      push(117, "ped_notrunc", 3'd3, 8'd2, R, G, 1'b1);
      drain();
      ped_req = 1'b0;
      push(120, "ped_keep",   3'd3, 8'd1, R, G, 1'b1);
      push(124, "ped_clr_ew", 3'd4, 8'd2, R, Y, 1'b0);
      push(136, "ns_g3",      3'd0, 8'd6, G, R, 1'b0);
      push(143, "pre_tick",   3'd0, 8'd5, G, R, 1'b0);
      drain();

      // Request coinciding with a tick: truncation wins over decrement
      ped_req = 1'b1;
      push(144, "ped_vs_tick", 3'd0, 8'd2, G, R, 1'b1);
      drain();
      ped_req = 1'b0;
      push(148, "trunc_tick", 3'd0, 8'd1, G, R, 1'b1);
      push(151, "pre_y",      3'd0, 8'd1, G, R, 1'b1);
      drain();

      // Held request across yellow entry: cleared there, re-armed one edge later
      ped_req = 1'b1;
      push(152, "held_clr",   3'd1, 8'd2, Y, R, 1'b0);
      push(153, "held_rearm", 3'd1, 8'd2, Y, R, 1'b1);
      drain();
      ped_req = 1'b0;
      push(154, "y_mid", 3'd1, 8'd2, Y, R, 1'b1);
      drain();

      // Enable dropped mid yellow
      enable = 1'b0;
      push(155, "dis_ar",   3'd5, 8'd1, R, R, 1'b1);
      push(158, "dis_hold", 3'd5, 8'd1, R, R, 1'b1);
      drain();
      enable = 1'b1;
      push(161, "reen_clear", 3'd5, 8'd1, R, R, 1'b1);
      push(162, "reen_ns_g",  3'd0, 8'd6, G, R, 1'b1);
      push(163, "reen_trunc", 3'd0, 8'd2, G, R, 1'b1);
      push(170, "reen_ns_y",  3'd1, 8'd2, Y, R, 1'b0);
      push(182, "ew_g4",      3'd3, 8'd6, R, G, 1'b0);
      push(186, "ew_g4_5",    3'd3, 8'd5, R, G, 1'b0);
      drain();

      // Asynchronous reset mid EW_GREEN, observed before the next clock edge
      #1 rstn = 1'b0;
      #1;
      rv.tag = "async_rst";
      snap(rv);
      @(negedge clk_100MHz);
      rstn = 1'b1;
      push(3, "rst2_ar2",  3'd5, 8'd1, R, R, 1'b0);
      push(4, "rst2_ns_g", 3'd0, 8'd6, G, R, 1'b0);
      drain();

`ifdef TRAFFIC_NIGHT_FLASH_EN
      push(36, "n_ar1", 3'd2, 8'd1, R, R, 1'b0);
      drain();
      night = 1'b1;
      push(40, "flash_on",  3'd6, 8'd0, Y, Y, 1'b0);
      push(44, "flash_off", 3'd6, 8'd0, O, O, 1'b0);
      push(48, "flash_on2", 3'd6, 8'd0, Y, Y, 1'b0);
      drain();
      night = 1'b0;
      push(52, "flash_exit", 3'd5, 8'd1, R, R, 1'b0);
      push(56, "flash_ns_g", 3'd0, 8'd6, G, R, 1'b0);
      drain();
`endif

      $display("%0d/%0d checks passed", npass, ntotal);
      $finish;
   end

endmodule
